// File: rtl/key_expansion_ctrl_if.sv
// Register-file and S-box bus between the key-expansion sequencer and the
// 64 x 32-bit key-schedule file plus its four combinational S-boxes.
// master: the sequencer; slave: the register file / S-box side.
interface key_expansion_ctrl_if;
   logic [5:0]  RF_Addr_Wr;
   logic [31:0] RF_Data;
   logic [5:0]  RF_Addr_A;
   logic [5:0]  RF_Addr_B;
   logic [31:0] RF_Out_A;
   logic [31:0] RF_Out_B;
   logic [31:0] Sbox_In;
   logic [31:0] Sbox_Out;

   modport master (
      output RF_Addr_Wr, RF_Data, RF_Addr_A, RF_Addr_B, Sbox_In,
      input  RF_Out_A, RF_Out_B, Sbox_Out
   );

   modport slave (
      input  RF_Addr_Wr, RF_Data, RF_Addr_A, RF_Addr_B, Sbox_In,
      output RF_Out_A, RF_Out_B, Sbox_Out
   );
endinterface

// File: rtl/key_expansion_ctrl.sv
// AES key-expansion sequencer. Loads a 128/192/256-bit key into the key
// register file, then generates w[Nk..Nw-1] one word per cycle, reading
// w[i-1] on port A and w[i-Nk] on port B and writing w[i] back.
// Optional macro KEY_EXPANSION_PIPE_EN splits each EXPAND word into a READ
// cycle (operands and XOR registered) and a WRITE cycle, cutting the
// read -> S-box -> write combinational path.
module key_expansion_ctrl #(
   parameter logic [5:0] PARK_ADDR = 6'd63,
   parameter logic [7:0] RCON_INIT = 8'h01
) (
   input  logic                       Clk,
   input  logic                       Rst,
   input  logic                       Start,
   input  logic [1:0]                 Key_Size,
   input  logic [255:0]               Key_In,
   key_expansion_ctrl_if.master       rf,
   output logic                       Busy,
   output logic                       Done,
   output logic                       Ready,
   output logic [3:0]                 Num_Rounds
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LOAD   = 2'd1;
   localparam logic [1:0] ST_EXPAND = 2'd2;

   logic [1:0]   state;
   logic [5:0]   idx;
   logic [2:0]   jdx;
   logic [3:0]   nk;
   logic [5:0]   nw;
   logic [7:0]   rcon;
   logic [255:0] key_q;

   logic [3:0]   dec_nk;
   logic [3:0]   dec_nr;
   logic [5:0]   dec_nw;
   logic         accept;
   logic [3:0]   nk_m1;
   logic         word_adv;
   logic         rcon_adv;
   logic [31:0]  sbox_in;
   logic [31:0]  temp;
   logic [31:0]  wr_word;
   logic [5:0]   wr_addr;
   logic [31:0]  wr_data;
   logic [5:0]   addr_a;
   logic [5:0]   addr_b;

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] r);
      return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
   endfunction

   // Word n of the left-aligned key: word 0 sits in bits [255:224].
   function automatic logic [31:0] key_word(input logic [255:0] k, input logic [2:0] n);
      logic [255:0] s;
      s = k << {n, 5'b0};
      return s[255:224];
   endfunction

   // Key-size decode: Nk/Nr/Nw for 128/192/256-bit keys.
   always_comb begin
      dec_nk = 4'd4;
      dec_nr = 4'd10;
      dec_nw = 6'd44;
      case (Key_Size)
         2'b01: begin dec_nk = 4'd6; dec_nr = 4'd12; dec_nw = 6'd52; end
         2'b10: begin dec_nk = 4'd8; dec_nr = 4'd14; dec_nw = 6'd60; end
         default: ;
      endcase
   end

   assign accept = (state == ST_IDLE) && Start && (Key_Size != 2'b11);
   assign nk_m1  = nk - 4'd1;
   assign Busy   = (state == ST_LOAD) || (state == ST_EXPAND);

`ifdef KEY_EXPANSION_PIPE_EN
   logic        vld_p0;
   logic [31:0] xor_p0;

   // READ/WRITE phase toggle inside EXPAND; vld_p0 marks the WRITE cycle.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst)                    vld_p0 <= 1'b0;
      else if (state == ST_EXPAND) vld_p0 <= ~vld_p0;
      else                         vld_p0 <= 1'b0;
   end

   // READ -> WRITE stage boundary: hold the XOR of w[i-Nk] and temp.
   always_ff @(posedge Clk) begin
      if ((state == ST_EXPAND) && !vld_p0) xor_p0 <= rf.RF_Out_B ^ temp;
   end

   assign word_adv = vld_p0;
   assign rcon_adv = !vld_p0 && (jdx == 3'd0);
   assign wr_word  = xor_p0;
`else
   assign word_adv = 1'b1;
   assign rcon_adv = (jdx == 3'd0);
   assign wr_word  = rf.RF_Out_B ^ temp;
`endif

   // Latch the cipher key on acceptance; later Key_In changes are ignored.
   always_ff @(posedge Clk) begin
      if (accept) key_q <= Key_In;
   end

   // Sequencer state, word counters, round constant and status flags.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state      <= ST_IDLE;
         idx        <= 6'd0;
         jdx        <= 3'd0;
         nk         <= 4'd4;
         nw         <= 6'd44;
         rcon       <= RCON_INIT;
         Done       <= 1'b0;
         Ready      <= 1'b0;
         Num_Rounds <= 4'd0;
      end else begin
         Done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  nk         <= dec_nk;
                  nw         <= dec_nw;
                  Num_Rounds <= dec_nr;
                  Ready      <= 1'b0;
                  idx        <= 6'd0;
                  state      <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (idx == {2'b00, nk_m1}) begin
                  state <= ST_EXPAND;
                  idx   <= {2'b00, nk};
                  jdx   <= 3'd0;
                  rcon  <= RCON_INIT;
               end else begin
                  idx <= idx + 6'd1;
               end
            end
            ST_EXPAND: begin
               if (rcon_adv) rcon <= xtime(rcon);
               if (word_adv) begin
                  if (idx == nw - 6'd1) begin
                     state <= ST_IDLE;
                     Done  <= 1'b1;
                     Ready <= 1'b1;
                  end else begin
                     idx <= idx + 6'd1;
                     jdx <= (jdx == nk_m1[2:0]) ? 3'd0 : jdx + 3'd1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // SubWord input: rotated w[i-1] at the start of each key-length group.
   always_comb begin
      sbox_in = 32'd0;
      if (state == ST_EXPAND) begin
         sbox_in = (jdx == 3'd0) ? rot_word(rf.RF_Out_A) : rf.RF_Out_A;
      end
   end

   // Read addresses, temp selection and the register-file write port.
   always_comb begin
      wr_addr = PARK_ADDR;
      wr_data = 32'd0;
      addr_a  = 6'd0;
      addr_b  = 6'd0;
      temp    = 32'd0;
      case (state)
         ST_LOAD: begin
            wr_addr = idx;
            wr_data = key_word(key_q, idx[2:0]);
         end
         ST_EXPAND: begin
            addr_a = idx - 6'd1;
            addr_b = idx - {2'b00, nk};
            if (jdx == 3'd0)                       temp = rf.Sbox_Out ^ {rcon, 24'h0};
            else if ((nk == 4'd8) && (jdx == 3'd4)) temp = rf.Sbox_Out;
            else                                   temp = rf.RF_Out_A;
            if (word_adv) begin
               wr_addr = idx;
               wr_data = wr_word;
            end
         end
         default: ;
      endcase
   end

   assign rf.RF_Addr_Wr = wr_addr;
   assign rf.RF_Data    = wr_data;
   assign rf.RF_Addr_A  = addr_a;
   assign rf.RF_Addr_B  = addr_b;
   assign rf.Sbox_In    = sbox_in;

endmodule

// File: doc/key_expansion_ctrl.md
Name: key_expansion_ctrl

Overview:
- Sequencer for the AES key-expansion register file, which holds 64 x 32-bit words, has one write port, two read ports and a 128-bit round-key read.
- Loads a 128/192/256-bit cipher key, then generates the full key schedule w[0..Nw-1] by driving the file's write address/data and its A/B read addresses.
- SubWord uses four external combinational S-boxes through the Sbox_In/Sbox_Out ports.
- Flags completion so the cipher core can fetch round keys through the file's key port.

Parameters:
- PARK_ADDR, 63, write address driven whenever no schedule word is being written. The file writes every cycle, so word 63 is scratch.
- RCON_INIT, 8'h01, first round constant.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Start  in  1  one-cycle request; sampled only in IDLE.
- Key_Size  in  2  00=AES-128, 01=AES-192, 10=AES-256, 11=invalid.
- Key_In  in  256  cipher key, left-aligned. Word 0 = Key_In[255:224]; unused low bits are ignored.
- RF_Addr_Wr  out  6  register-file write address.
- RF_Data  out  32  register-file write data.
- RF_Addr_A  out  6  read address A, carries w[i-1].
- RF_Addr_B  out  6  read address B, carries w[i-Nk].
- RF_Out_A  in  32  read data A.
- RF_Out_B  in  32  read data B.
- Sbox_In  out  32  SubWord input.
- Sbox_Out  in  32  SubWord result, combinational.
- Busy  out  1  high in LOAD/EXPAND.
- Done  out  1  one-cycle pulse after the last word is written.
- Ready  out  1  schedule valid; high from Done until the next accepted Start.
- Num_Rounds  out  4  Nr of the latched size: 10/12/14. Stable while Ready.

Behaviour:
- Reset values: state IDLE, RF_Addr_Wr=PARK_ADDR, RF_Data=0, RF_Addr_A=0, RF_Addr_B=0, Busy=0, Done=0, Ready=0, Num_Rounds=0.
- Size decode: Nk=4/6/8, Nr=10/12/14, Nw=44/52/60.
- IDLE:
  - Start=1 with Key_Size!=11 latches Key_In, Nk and Nr; clears Ready; goes to LOAD.
  - Start with Key_Size=11 is ignored; state stays IDLE and all outputs are unchanged.
- LOAD: one word per cycle, i=0..Nk-1. RF_Addr_Wr=i, RF_Data=key word i. After word Nk-1, go to EXPAND with i=Nk, j=0 (j = i mod Nk), rcon=RCON_INIT.
- EXPAND, one word per cycle:
  - RF_Addr_A=i-1, RF_Addr_B=i-Nk, RF_Addr_Wr=i.
  - j==0: Sbox_In=RotWord(RF_Out_A); temp=Sbox_Out ^ {rcon,24'h0}; rcon advances to xtime(rcon) (shift left 1, XOR 8'h1B if bit 7 was set).
  - Nk==8 and j==4: Sbox_In=RF_Out_A; temp=Sbox_Out.
  - All other cases: Sbox_In=RF_Out_A; temp=RF_Out_A.
  - RF_Data=RF_Out_B ^ temp.
  - j wraps to 0 at Nk-1.
- Write i=Nw-1 ends the schedule. The next cycle goes to IDLE with Done=1 for one cycle and Ready=1.
- Outside LOAD/EXPAND: RF_Addr_Wr=PARK_ADDR, RF_Data=0.
- Latency from the accepted Start edge to Done: Nw+1 cycles, i.e. 45/53/61.
- Start while Busy is ignored. Key_In and Key_Size changes after acceptance have no effect.
- Reset mid-operation: returns to IDLE at once with all reset values. Words already written stay in the file; Ready=0 marks them invalid.
- Words 60..62 are never written. Word 63 receives parking writes.

Optional Feature:
- Macro: KEY_EXPANSION_PIPE_EN.
- When defined:
  - EXPAND takes two cycles per word. READ registers temp and RF_Out_B; WRITE drives RF_Addr_Wr=i and RF_Data=registered XOR.
  - This cuts the read -> S-box -> write combinational path.
  - RF_Addr_Wr=PARK_ADDR during READ.
  - Done latency becomes Nk+2*(Nw-Nk)+1 cycles: 85/99/113.
- When undefined: the one-word-per-cycle behaviour above.

Test Plan:
- AES-128, Key_In[255:128]=2b7e1516_28aed2a6_abf71588_09cf4f3c -> w4=a0fafe17, w43=b6630ca6. Done exactly 45 cycles after Start (85 with KEY_EXPANSION_PIPE_EN). Num_Rounds=10.
- AES-192, key 8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b -> w6=fe0c91f7, w51=01002202. Num_Rounds=12. Words 52..62 untouched.
- AES-256, key 603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4 -> w8=9ba35411, w12 shows the j==4 SubWord path, w59=706c631e. Num_Rounds=14.
- Start pulsed at cycle 10 of a running AES-128 job, with Key_In changed -> ignored. Schedule still matches the first key. Single Done pulse.
- Rst low at cycle 20 of an AES-256 job -> Busy=0, Ready=0, RF_Addr_Wr=63 during reset. A new AES-128 Start then completes correctly, with rcon restarting at 01.
- Start with Key_Size=11 -> stays IDLE, no file writes except to address 63, Done never asserted.
